wb_arbiter_m1: RTL and testbench

WB_ARBITER_M1 -- requirements
Module: wb_arbiter_m1

---
 rtl/wb_arbiter_m1_pkg.sv | 39 +++
 rtl/wb_arbiter_m1_rr_arb2.sv | 50 +++++
 rtl/wb_arbiter_m1.sv | 139 +++++++++++++
 tb/tb_wb_arbiter_m1.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_m1_pkg.sv
// Types_m1
// Shared types for the writeback arbiter slice.
//   wb_req_t  : one result beat {valid, addr, data}. It describes every
//               source port and the ALU hold register.
//   wb_src_e  : which source drives the output register in a cycle.
//   packReq() : builds a wb_req_t from the flat valid/addr/data ports.
package Types_m1;

    localparam int unsigned AddrW = 4;
    localparam int unsigned DataW = 16;

    typedef struct packed {
        logic             valid;
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] data;
    } wb_req_t;

    localparam wb_req_t WbReqIdle = '0;

    typedef enum logic [2:0] {
        SrcNone,
        SrcMul,
        SrcHold,
        SrcAlu,
        SrcDiv,
        SrcLsu
    } wb_src_e;

    function automatic wb_req_t packReq(input logic valid,
                                        input logic [AddrW-1:0] addr,
                                        input logic [DataW-1:0] data);
        wb_req_t req;
        req.valid = valid;
        req.addr  = addr;
        req.data  = data;
        return req;
    endfunction

endpackage

// File: rtl/wb_arbiter_m1_rr_arb2.sv
// rr_arb2_m1
// Two-way round-robin selector for the DIV/LSU writeback sources.
// Ports:
//   clk, rst  : core clock and synchronous active-high reset
//   req[1:0]  : bit 0 = DIV, bit 1 = LSU. Requests arrive already gated
//               by the parent, so a set bit is always grantable.
//   grant[1:0]: one-hot (or zero) grant. Combinational from req and the
//               last-grant flop.
module rr_arb2_m1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // lastGrant_q is 1 when DIV won the most recent grant. It resets to 0,
    // so DIV wins the first contested cycle.
    logic lastGrant_q;
    logic lastGrant_d;

    // When both sources request, the one that did not win last time wins.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = lastGrant_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // The pointer moves only when something is actually granted.
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grant[0]) begin
            lastGrant_d = 1'b1;
        end else if (grant[1]) begin
            lastGrant_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= 1'b0;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_m1.sv
// wb_arbiter_m1
// Merges four execution-unit results onto one registered regfile write port.
// Ports:
//   clk, rst                    : core clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data : ALU result. It cannot be stalled.
//   mul_valid/mul_addr/mul_data : final-stage MUL result. It cannot be stalled.
//   mul_pending                 : the MUL presents a result next cycle
//   div_valid/div_addr/div_data : DIV result, valid/ready handshake
//   div_ready                   : DIV result accepted this cycle
//   lsu_valid/lsu_addr/lsu_data : LSU load result, valid/ready handshake
//   lsu_ready                   : LSU result accepted this cycle
//   wb_en/wb_addr/wb_data       : registered write and forwarding port
//   wb_conflict_stall           : the issue stage must not dispatch an ALU op
//   wb_empty                    : nothing is held in this block or in flight
module wb_arbiter_m1
    import Types_m1::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [AddrW-1:0] alu_addr,
    input  logic [DataW-1:0] alu_data,
    input  logic             mul_valid,
    input  logic [AddrW-1:0] mul_addr,
    input  logic [DataW-1:0] mul_data,
    input  logic             mul_pending,
    input  logic             div_valid,
    input  logic [AddrW-1:0] div_addr,
    input  logic [DataW-1:0] div_data,
    output logic             div_ready,
    input  logic             lsu_valid,
    input  logic [AddrW-1:0] lsu_addr,
    input  logic [DataW-1:0] lsu_data,
    output logic             lsu_ready,
    output logic             wb_en,
    output logic [AddrW-1:0] wb_addr,
    output logic [DataW-1:0] wb_data,
    output logic             wb_conflict_stall,
    output logic             wb_empty
);

    wb_req_t aluReq;
    wb_req_t mulReq;
    wb_req_t divReq;
    wb_req_t lsuReq;

    wb_req_t hold_q;
    wb_req_t hold_d;
    wb_req_t wbOut_q;
    wb_req_t wbOut_d;

    wb_src_e    wbSrc;
    logic       arbOpen;
    logic [1:0] rrReq;
    logic [1:0] rrGrant;

    assign aluReq = packReq(alu_valid, alu_addr, alu_data);
    assign mulReq = packReq(mul_valid, mul_addr, mul_data);
    assign divReq = packReq(div_valid, div_addr, div_data);
    assign lsuReq = packReq(lsu_valid, lsu_addr, lsu_data);

    // DIV and LSU only compete in cycles where none of the unstallable
    // sources, including the held ALU result, needs the write port.
    assign arbOpen = !mulReq.valid && !aluReq.valid && !hold_q.valid;
    assign rrReq   = {lsuReq.valid, divReq.valid} & {2{arbOpen}};

    rr_arb2_m1 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (rrReq),
        .grant (rrGrant)
    );

    assign div_ready = rrGrant[0];
    assign lsu_ready = rrGrant[1];

    // Pick the source for this cycle and update the hold register.
    // MUL always wins and pushes a coincident ALU result into the hold
    // slot. A held result drains on the first cycle without MUL. A fresh
    // ALU result arriving in that cycle takes the slot in its place.
    always_comb begin
        wbSrc  = SrcNone;
        hold_d = hold_q;
        if (mulReq.valid) begin
            wbSrc = SrcMul;
            if (aluReq.valid && !hold_q.valid) begin
                hold_d = aluReq;
            end
        end else if (hold_q.valid) begin
            wbSrc  = SrcHold;
            hold_d = aluReq.valid ? aluReq : WbReqIdle;
        end else if (aluReq.valid) begin
            wbSrc = SrcAlu;
        end else if (rrGrant[0]) begin
            wbSrc = SrcDiv;
        end else if (rrGrant[1]) begin
            wbSrc = SrcLsu;
        end
    end

    // Steer the selected source onto the next output register value.
    // In an idle cycle only the valid bit drops. The address and data
    // keep their last values for the forwarding network.
    always_comb begin
        wbOut_d       = wbOut_q;
        wbOut_d.valid = 1'b0;
        unique case (wbSrc)
            SrcMul:  wbOut_d = mulReq;
            SrcHold: wbOut_d = hold_q;
            SrcAlu:  wbOut_d = aluReq;
            SrcDiv:  wbOut_d = divReq;
            SrcLsu:  wbOut_d = lsuReq;
            default: wbOut_d.valid = 1'b0;
        endcase
    end

    // Reset discards the hold slot and the output register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= WbReqIdle;
            wbOut_q <= WbReqIdle;
        end else begin
            hold_q  <= hold_d;
            wbOut_q <= wbOut_d;
        end
    end

    assign wb_en             = wbOut_q.valid;
    assign wb_addr           = wbOut_q.addr;
    assign wb_data           = wbOut_q.data;
    assign wb_conflict_stall = mul_pending | hold_q.valid;
    assign wb_empty          = !hold_q.valid && !wbOut_q.valid;

    // An ALU result arriving while the slot is full and MUL also writes has
    // nowhere to go. The issue stall should make this unreachable.
    holdOverflow: assert property (@(posedge clk) disable iff (rst)
        !(hold_q.valid && aluReq.valid && mulReq.valid));

endmodule

// File: tb/tb_wb_arbiter_m1.sv
// tb_wb_arbiter_m1
// Directed, table-driven bench for wb_arbiter_m1, plus hand-written
// sequences for a stalled LSU and for reset with a held result.
module tb_wb_arbiter_m1;
    import Types_m1::*;

    logic             clk;
    logic             rst;
    logic             alu_valid, mul_valid, mul_pending, div_valid, lsu_valid;
    logic [AddrW-1:0] alu_addr, mul_addr, div_addr, lsu_addr;
    logic [DataW-1:0] alu_data, mul_data, div_data, lsu_data;
    logic             div_ready, lsu_ready, wb_en, wb_conflict_stall, wb_empty;
    logic [AddrW-1:0] wb_addr;
    logic [DataW-1:0] wb_data;

    int checks = 0;
    int passed = 0;

    typedef struct {
        wb_req_t          alu;
        wb_req_t          mul;
        logic             pend;
        wb_req_t          div;
        wb_req_t          lsu;
        logic             eDivRdy;
        logic             eLsuRdy;
        logic             eStall;
        logic             eEn;
        logic [AddrW-1:0] eAddr;
        logic [DataW-1:0] eData;
        logic             eEmpty;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs[NumVec];
    localparam wb_req_t N = '0;

    wb_arbiter_m1 dut (
        .clk               (clk),
        .rst               (rst),
        .alu_valid         (alu_valid),
        .alu_addr          (alu_addr),
        .alu_data          (alu_data),
        .mul_valid         (mul_valid),
        .mul_addr          (mul_addr),
        .mul_data          (mul_data),
        .mul_pending       (mul_pending),
        .div_valid         (div_valid),
        .div_addr          (div_addr),
        .div_data          (div_data),
        .div_ready         (div_ready),
        .lsu_valid         (lsu_valid),
        .lsu_addr          (lsu_addr),
        .lsu_data          (lsu_data),
        .lsu_ready         (lsu_ready),
        .wb_en             (wb_en),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .wb_conflict_stall (wb_conflict_stall),
        .wb_empty          (wb_empty)
    );

    // 10 ns core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic wb_req_t r(input logic [3:0] a, input logic [15:0] d);
        return packReq(1'b1, a, d);
    endfunction

    // Compare one observed value against its expected value and keep score.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive all source ports from the given requests.
    task automatic driveInputs(input wb_req_t alu, input wb_req_t mul,
                               input logic pend, input wb_req_t div,
                               input wb_req_t lsu);
        {alu_valid, alu_addr, alu_data} = alu;
        {mul_valid, mul_addr, mul_data} = mul;
        mul_pending                     = pend;
        {div_valid, div_addr, div_data} = div;
        {lsu_valid, lsu_addr, lsu_data} = lsu;
    endtask

    // Apply one vector. Check the combinational outputs before the edge and
    // the registered outputs 1 ns after it.
    task automatic applyStimulus(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        driveInputs(vecs[idx].alu, vecs[idx].mul, vecs[idx].pend,
                    vecs[idx].div, vecs[idx].lsu);
        #1;
        checkOutput({tag, ".div_ready"}, 32'(div_ready), 32'(vecs[idx].eDivRdy));
        checkOutput({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(vecs[idx].eLsuRdy));
        checkOutput({tag, ".stall"}, 32'(wb_conflict_stall), 32'(vecs[idx].eStall));
        @(posedge clk);
        #1;
        checkOutput({tag, ".wb_en"}, 32'(wb_en), 32'(vecs[idx].eEn));
        checkOutput({tag, ".wb_addr"}, 32'(wb_addr), 32'(vecs[idx].eAddr));
        checkOutput({tag, ".wb_data"}, 32'(wb_data), 32'(vecs[idx].eData));
        checkOutput({tag, ".wb_empty"}, 32'(wb_empty), 32'(vecs[idx].eEmpty));
    endtask

    task automatic stepIdle();
        driveInputs(N, N, 1'b0, N, N);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         alu            mul            pd    div            lsu            dR    lR    st    en    addr  data      empty
        vecs[0]  = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1};
        vecs[1]  = '{r(3,16'h1234), N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 16'h1234, 1'b0};
        vecs[2]  = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 16'h1234, 1'b1};
        vecs[3]  = '{r(2,16'hAAAA), r(5,16'h5555), 1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 16'h5555, 1'b0};
        vecs[4]  = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 16'hAAAA, 1'b0};
        vecs[5]  = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'hAAAA, 1'b1};
        vecs[6]  = '{N,            N,            1'b1, N,            N,            1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 16'hAAAA, 1'b1};
        vecs[7]  = '{N,            N,            1'b0, r(4,16'h0004), r(6,16'h0006), 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 16'h0004, 1'b0};
        vecs[8]  = '{N,            N,            1'b0, N,            r(6,16'h0006), 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 16'h0006, 1'b0};
        vecs[9]  = '{N,            N,            1'b0, r(4,16'h0004), r(6,16'h0006), 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 16'h0004, 1'b0};
        vecs[10] = '{N,            N,            1'b0, r(4,16'h0004), r(6,16'h0006), 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 16'h0006, 1'b0};
        vecs[11] = '{r(0,16'hBEEF), N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'hBEEF, 1'b0};
        vecs[12] = '{r(7,16'h0707), N,            1'b0, r(8,16'h0808), N,            1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 16'h0707, 1'b0};
        vecs[13] = '{N,            N,            1'b0, r(8,16'h0808), N,            1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 16'h0808, 1'b0};
        vecs[14] = '{r(9,16'h0009), r(1,16'h0001), 1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 16'h0001, 1'b0};
        vecs[15] = '{r(10,16'h000A), N,           1'b0, N,            N,            1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 16'h0009, 1'b0};
        vecs[16] = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 16'h000A, 1'b0};
        vecs[17] = '{N,            N,            1'b0, N,            N,            1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 16'h000A, 1'b1};
        vecs[18] = '{N,            N,            1'b0, N,            r(11,16'h00BB), 1'b0, 1'b1, 1'b0, 1'b1, 4'hB, 16'h00BB, 1'b0};
        vecs[19] = '{N,            r(12,16'h0C0C), 1'b0, N,          r(13,16'h00DD), 1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 16'h0C0C, 1'b0};

        rst = 1'b1;
        driveInputs(N, N, 1'b0, N, N);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.wb_en", 32'(wb_en), 32'd0);
        checkOutput("reset.wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("reset.wb_data", 32'(wb_data), 32'd0);
        checkOutput("reset.wb_empty", 32'(wb_empty), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            applyStimulus(i);
        end

        // LSU waits behind three MUL writes, then goes through.
        for (int c = 0; c < 3; c++) begin
            driveInputs(N, r(4'(c + 1), 16'(16'h1111 * (c + 1))), 1'b0, N,
                        r(14, 16'h00EE));
            #1;
            checkOutput($sformatf("lsuStall%0d.lsu_ready", c), 32'(lsu_ready), 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("lsuStall%0d.wb_addr", c), 32'(wb_addr), 32'(c + 1));
            checkOutput($sformatf("lsuStall%0d.wb_data", c), 32'(wb_data),
                        32'(16'h1111 * (c + 1)));
        end
        driveInputs(N, N, 1'b0, N, r(14, 16'h00EE));
        #1;
        checkOutput("lsuGo.lsu_ready", 32'(lsu_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("lsuGo.wb_en", 32'(wb_en), 32'd1);
        checkOutput("lsuGo.wb_addr", 32'(wb_addr), 32'hE);
        checkOutput("lsuGo.wb_data", 32'(wb_data), 32'h00EE);

        // Reset while the hold slot is full throws the held result away.
        driveInputs(r(2, 16'hAAAA), r(5, 16'h5555), 1'b0, N, N);
        @(posedge clk);
        #1;
        driveInputs(N, N, 1'b0, N, N);
        #1;
        checkOutput("holdRst.stallBefore", 32'(wb_conflict_stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("holdRst.wb_en", 32'(wb_en), 32'd0);
        checkOutput("holdRst.wb_empty", 32'(wb_empty), 32'd1);
        checkOutput("holdRst.wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("holdRst.stall", 32'(wb_conflict_stall), 32'd0);
        for (int c = 0; c < 3; c++) begin
            stepIdle();
            checkOutput($sformatf("holdRst.idle%0d.wb_en", c), 32'(wb_en), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
